// File: rtl/burst_mem_if.sv
// Burst memory request/response bundle between the L1 cache (master) and
// the system-side backing memory (slave).
interface burst_mem_if #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DATA_ADDR_WIDTH = 32
);
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_write;
   logic [DATA_ADDR_WIDTH-1:0] req_addr;
   logic                       rd_valid;
   logic [DATA_WIDTH-1:0]      rd_data;
   logic                       rd_last;
   logic                       wr_valid;
   logic                       wr_ready;
   logic [DATA_WIDTH-1:0]      wr_data;
   logic                       wr_last;
   logic                       wr_done;
   logic                       proto_err;

   modport master (
      output req_valid, req_write, req_addr, wr_valid, wr_data, wr_last,
      input  req_ready, rd_valid, rd_data, rd_last, wr_ready, wr_done, proto_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, wr_valid, wr_data, wr_last,
      output req_ready, rd_valid, rd_data, rd_last, wr_ready, wr_done, proto_err
   );
endinterface

// File: rtl/burst_mem_responder.sv
// Backing memory answering cache line refills (read bursts after a fixed
// latency) and write-backs (write bursts acknowledged with a done pulse).
module burst_mem_responder #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DATA_ADDR_WIDTH = 32,
   parameter int unsigned NUM_WORDS       = 512,
   parameter int unsigned READ_BURST_LEN  = 8,
   parameter int unsigned WRITE_BURST_LEN = 8,
   parameter int unsigned RD_LATENCY      = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   burst_mem_if.slave    bus
);

   localparam int unsigned WORD_AW = $clog2(NUM_WORDS);
   localparam int unsigned RD_BW   = $clog2(READ_BURST_LEN);
   localparam int unsigned WR_BW   = $clog2(WRITE_BURST_LEN);
   localparam int unsigned BEAT_W  = (RD_BW > WR_BW) ? RD_BW : WR_BW;
   localparam int unsigned LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [WORD_AW-1:0] RD_MASK      = WORD_AW'(READ_BURST_LEN - 1);
   localparam logic [WORD_AW-1:0] WR_MASK      = WORD_AW'(WRITE_BURST_LEN - 1);
   localparam logic [BEAT_W-1:0]  RD_LAST_BEAT = BEAT_W'(READ_BURST_LEN - 1);
   localparam logic [BEAT_W-1:0]  WR_LAST_BEAT = BEAT_W'(WRITE_BURST_LEN - 1);
   localparam logic [LAT_W-1:0]   LAT_INIT     = LAT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_BURST,
      S_WR_BURST,
      S_WR_RESP
   } state_e;

   state_e               state_q, state_d;
   logic [WORD_AW-1:0]   base_q, base_d;
   logic [LAT_W-1:0]     lat_q, lat_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;

   logic                  req_ready_q, req_ready_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_last_q, rd_last_d;
   logic                  wr_ready_q, wr_ready_d;
   logic                  wr_done_q, wr_done_d;
   logic                  proto_err_q, proto_err_d;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic [WORD_AW-1:0] req_idx_c;
   logic [WORD_AW-1:0] wr_addr_c;
   logic [WORD_AW-1:0] rd_addr_c;
   logic               wr_fire_c;
   logic               wr_final_c;

   // Byte offset and bits above the memory depth are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.req_addr[1:0],
                               bus.req_addr[DATA_ADDR_WIDTH-1:WORD_AW+2]};

   assign req_idx_c  = bus.req_addr[2 +: WORD_AW];
   assign wr_fire_c  = (state_q == S_WR_BURST) && bus.wr_valid;
   assign wr_final_c = (beat_q == WR_LAST_BEAT);
   assign wr_addr_c  = base_q + WORD_AW'(beat_q);
   assign rd_addr_c  = base_q + WORD_AW'(beat_d);

   // State and output registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         lat_q       <= '0;
         beat_q      <= '0;
         req_ready_q <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_last_q   <= 1'b0;
         wr_ready_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         req_ready_q <= req_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_last_q   <= rd_last_d;
         wr_ready_q  <= wr_ready_d;
         wr_done_q   <= wr_done_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Storage is never reset; beats written before a reset survive it.
   always_ff @(posedge sys_clk) begin
      if (wr_fire_c) begin
         mem[wr_addr_c] <= bus.wr_data;
      end
   end

   // Next-state: request capture, latency countdown, beat sequencing
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_write) begin
                  base_d  = req_idx_c & ~WR_MASK;
                  beat_d  = '0;
                  state_d = S_WR_BURST;
               end else begin
                  base_d  = req_idx_c & ~RD_MASK;
                  lat_d   = LAT_INIT;
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (lat_q == '0) begin
               beat_d  = '0;
               state_d = S_RD_BURST;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_RD_BURST: begin
            if (beat_q == RD_LAST_BEAT) begin
               state_d = S_IDLE;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_WR_BURST: begin
            if (bus.wr_valid) begin
               if (wr_final_c) begin
                  state_d = S_WR_RESP;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_WR_RESP: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output next values follow the upcoming state so every output is a flop
   always_comb begin
      req_ready_d = (state_d == S_IDLE);
      rd_valid_d  = (state_d == S_RD_BURST);
      rd_data_d   = '0;
      rd_last_d   = 1'b0;
      wr_ready_d  = (state_d == S_WR_BURST);
      wr_done_d   = (state_d == S_WR_RESP);
      proto_err_d = proto_err_q;
      if (rd_valid_d) begin
         rd_data_d = mem[rd_addr_c];
         rd_last_d = (beat_d == RD_LAST_BEAT);
      end
      // wr_last is advisory: a mismatch only flags, the beat count still rules
      if (wr_fire_c && (bus.wr_last != wr_final_c)) begin
         proto_err_d = 1'b1;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.wr_ready  = wr_ready_q;
   assign bus.wr_done   = wr_done_q;
   assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed plus randomized bench for burst_mem_responder against an
// array-based model of the memory and the burst timing rules.
module tb_burst_mem_responder;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam int unsigned NW   = 512;
   localparam int unsigned RLEN = 8;
   localparam int unsigned WLEN = 8;
   localparam int unsigned RL   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   burst_mem_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) bus ();

   burst_mem_responder #(
      .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW),
      .READ_BURST_LEN(RLEN), .WRITE_BURST_LEN(WLEN), .RD_LATENCY(RL)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .bus      (bus.slave)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [NW];
   bit          exp_err = 1'b0;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned word_base(input logic [31:0] addr, input int unsigned len);
      return ((addr >> 2) % NW) & ~(len - 1);
   endfunction

   task automatic check_reset_vals(input string tag);
      check1({tag, "_req_ready"}, bus.req_ready, 1'b1);
      check1({tag, "_rd_valid"},  bus.rd_valid,  1'b0);
      check32({tag, "_rd_data"},  bus.rd_data,   32'h0);
      check1({tag, "_rd_last"},   bus.rd_last,   1'b0);
      check1({tag, "_wr_ready"},  bus.wr_ready,  1'b0);
      check1({tag, "_wr_done"},   bus.wr_done,   1'b0);
      check1({tag, "_proto_err"}, bus.proto_err, 1'b0);
   endtask

   // One read burst; hold keeps req_valid asserted (with next_addr) afterwards.
   task automatic do_read(input logic [31:0] addr, input bit hold, input logic [31:0] next_addr);
      int unsigned base;
      bit          in_burst;
      base = word_base(addr, RLEN);
      check1("rd_accept_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = addr;
      tick();
      bus.req_valid = hold;
      bus.req_addr  = next_addr;
      check1("rd_busy", bus.req_ready, 1'b0);
      for (int c = 1; c <= int'(RL + RLEN); c++) begin
         tick();
         in_burst = (c >= int'(RL)) && (c < int'(RL + RLEN));
         check1("rd_valid", bus.rd_valid, in_burst);
         check32("rd_data", bus.rd_data, in_burst ? ref_mem[base + c - RL] : 32'h0);
         check1("rd_last", bus.rd_last, c == int'(RL + RLEN - 1));
         check1("rd_req_ready", bus.req_ready, c == int'(RL + RLEN));
      end
      check1("rd_proto_err", bus.proto_err, exp_err);
   endtask

   // One write burst with an optional gap before gap_beat and wr_last on last_beat.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] d [WLEN],
                           input int gap_beat, input int gap_len, input int last_beat);
      int unsigned base;
      base = word_base(addr, WLEN);
      check1("wr_accept_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = addr;
      tick();
      bus.req_valid = 1'b0;
      check1("wr_ready_up", bus.wr_ready, 1'b1);
      check1("wr_busy", bus.req_ready, 1'b0);
      for (int k = 0; k < int'(WLEN); k++) begin
         if (k == gap_beat) begin
            for (int g = 0; g < gap_len; g++) begin
               bus.wr_valid = 1'b0;
               tick();
               check1("wr_gap_ready", bus.wr_ready, 1'b1);
               check1("wr_gap_done", bus.wr_done, 1'b0);
            end
         end
         bus.wr_valid = 1'b1;
         bus.wr_data  = d[k];
         bus.wr_last  = (k == last_beat);
         if ((k == last_beat) != (k == int'(WLEN - 1))) exp_err = 1'b1;
         ref_mem[base + k] = d[k];
         tick();
         if (k < int'(WLEN - 1)) begin
            check1("wr_mid_ready", bus.wr_ready, 1'b1);
            check1("wr_mid_done", bus.wr_done, 1'b0);
         end
      end
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      check1("wr_ready_drop", bus.wr_ready, 1'b0);
      check1("wr_done_pulse", bus.wr_done, 1'b1);
      check1("wr_proto_err", bus.proto_err, exp_err);
      tick();
      check1("wr_done_clear", bus.wr_done, 1'b0);
      check1("wr_idle_ready", bus.req_ready, 1'b1);
   endtask

   initial begin
      logic [31:0] wd [WLEN];
      logic [31:0] v;
      logic [31:0] perr_addr;

      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.wr_last   = 1'b0;

      for (int i = 0; i < int'(NW); i++) begin
         v = $urandom;
         ref_mem[i] = v;
         dut.mem[i] = v;
      end
      for (int i = 0; i < 8; i++) begin
         ref_mem[8 + i] = 32'h100 + 32'(i);
         dut.mem[8 + i] = 32'h100 + 32'(i);
      end
      tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      check_reset_vals("post_rst");

      // Aligned then unaligned read of the same line
      do_read(32'h20, 1'b0, 32'h0);
      do_read(32'h2C, 1'b0, 32'h0);

      // Write with a two-cycle gap, then read it back
      for (int k = 0; k < int'(WLEN); k++) wd[k] = 32'hA0 + 32'(k);
      do_write(32'h40, wd, 4, 2, int'(WLEN - 1));
      do_read(32'h40, 1'b0, 32'h0);

      // Stray write beats while idle must not touch memory
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = $urandom;
         bus.wr_last  = 1'($urandom_range(0, 1));
         tick();
         check1("stray_wr_ready", bus.wr_ready, 1'b0);
         check1("stray_wr_done", bus.wr_done, 1'b0);
      end
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      do_read(32'h40, 1'b0, 32'h0);

      // Request held during a busy read is taken only once idle
      do_read(32'h20, 1'b1, 32'h40);
      do_read(32'h40, 1'b0, 32'h0);

      // wr_last on beat 3: burst still runs 8 beats, error sticks
      perr_addr = $urandom;
      for (int k = 0; k < int'(WLEN); k++) wd[k] = $urandom;
      do_write(perr_addr, wd, 0, 0, 3);
      check1("perr_set", bus.proto_err, 1'b1);
      do_read(perr_addr, 1'b0, 32'h0);
      check1("perr_sticky", bus.proto_err, 1'b1);

      // Reset in the middle of a read burst
      check1("rst_rd_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h20;
      tick();
      bus.req_valid = 1'b0;
      for (int c = 0; c < int'(RL + 4); c++) tick();
      check1("rst_rd_mid_valid", bus.rd_valid, 1'b1);
      check32("rst_rd_mid_data", bus.rd_data, ref_mem[12]);
      rst_n = 1'b0;
      tick();
      exp_err = 1'b0;
      check_reset_vals("mid_rst");
      rst_n = 1'b1;
      tick();
      do_read(32'h20, 1'b0, 32'h0);

      // Randomized mix of bursts with correct framing
      for (int it = 0; it < 8; it++) begin
         v = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < int'(WLEN); k++) wd[k] = $urandom;
            do_write(v, wd, int'($urandom_range(0, WLEN - 1)),
                     int'($urandom_range(0, 3)), int'(WLEN - 1));
            do_read(v, 1'b0, 32'h0);
         end else begin
            do_read(v, 1'b0, 32'h0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
